// File: rtl/pipe_tag_ctrl.sv
// rtl/pipe_tag_ctrl.sv - instruction-tag sequencer for the 5-stage pipeline trace
module pipe_tag_ctrl #(
    parameter int MAX_TAGS = 72,
    parameter int TAG_W    = 7,
    parameter int SCNT_W   = 4,
    parameter int RCNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              stall,
    input  logic              flush,
    output logic              if_vld,
    output logic              id_vld,
    output logic              ex_vld,
    output logic              mem_vld,
    output logic              wb_vld,
    output logic [TAG_W-1:0]  if_tag,
    output logic [TAG_W-1:0]  id_tag,
    output logic [TAG_W-1:0]  ex_tag,
    output logic [TAG_W-1:0]  mem_tag,
    output logic [TAG_W-1:0]  wb_tag,
    output logic              retire,
    output logic [TAG_W-1:0]  retire_tag,
    output logic [SCNT_W-1:0] retire_stalls,
    output logic              kill,
    output logic [TAG_W-1:0]  kill_tag,
    output logic              tags_exhausted,
    output logic [RCNT_W-1:0] retired_count
);

    localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(MAX_TAGS - 1);

    logic [TAG_W-1:0]  next_tag;
    logic [SCNT_W-1:0] if_sc, id_sc, ex_sc, mem_sc, wb_sc;
    logic              issue_ok;

    assign issue_ok      = en && !tags_exhausted;
    assign retire        = wb_vld;
    assign retire_tag    = wb_tag;
    assign retire_stalls = wb_sc;

    function automatic logic [SCNT_W-1:0] sc_inc(input logic [SCNT_W-1:0] sc);
        return (sc == {SCNT_W{1'b1}}) ? sc : sc + SCNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {if_vld, id_vld, ex_vld, mem_vld, wb_vld} <= '0;
            if_tag         <= '0;
            id_tag         <= '0;
            ex_tag         <= '0;
            mem_tag        <= '0;
            wb_tag         <= '0;
            if_sc          <= '0;
            id_sc          <= '0;
            ex_sc          <= '0;
            mem_sc         <= '0;
            wb_sc          <= '0;
            next_tag       <= '0;
            kill           <= 1'b0;
            kill_tag       <= '0;
            tags_exhausted <= 1'b0;
            retired_count  <= '0;
        end else begin
            // MEM and WB advance unconditionally; neither hazard reaches them
            wb_vld        <= mem_vld;
            wb_tag        <= mem_tag;
            wb_sc         <= mem_sc;
            mem_vld       <= ex_vld;
            mem_tag       <= ex_tag;
            mem_sc        <= ex_sc;
            retired_count <= retired_count + RCNT_W'(mem_vld);

            if (stall) begin
                ex_vld <= 1'b0;
                ex_tag <= '0;
                ex_sc  <= '0;
                kill   <= 1'b0;
                if (if_vld) if_sc <= sc_inc(if_sc);
                if (id_vld) id_sc <= sc_inc(id_sc);
            end else begin
                ex_vld <= id_vld;
                ex_tag <= id_tag;
                ex_sc  <= id_sc;
                if (flush) begin
                    id_vld <= 1'b0;
                    id_tag <= '0;
                    id_sc  <= '0;
                    kill   <= if_vld;
                    if (if_vld) kill_tag <= if_tag;
                end else begin
                    id_vld <= if_vld;
                    id_tag <= if_tag;
                    id_sc  <= if_sc;
                    kill   <= 1'b0;
                end

                if (issue_ok) begin
                    if_vld   <= 1'b1;
                    if_tag   <= next_tag;
                    if_sc    <= '0;
                    next_tag <= next_tag + TAG_W'(1);
                    if (next_tag == LAST_TAG) tags_exhausted <= 1'b1;
                end else begin
                    if_vld <= 1'b0;
                    if_tag <= '0;
                    if_sc  <= '0;
                end
            end
        end
    end

endmodule
